// File: rtl/queue.sv
`default_nettype none
// ============================================================================
//  Module      : queue
//  Description : In-order issue queue with CDB label capture and a
//                require/requireAC handshake on the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module queue #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 5
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               WEN,
    input  logic               opIn,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               isFull,
    output logic               require,
    input  logic               requireAC,
    output logic               opOut,
    output logic [DATA_W-1:0]  dataOut,
    output logic [LABEL_W-1:0] labelOut,
    input  logic               BCEN,
    input  logic [LABEL_W-1:0] BClabel,
    input  logic [DATA_W-1:0]  BCdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic               op_q    [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [LABEL_W-1:0] label_q [DEPTH];
    logic               valid_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_bc_hit;
    logic w_bypass;

    assign w_empty  = (count_q == '0);
    assign isFull   = (count_q == CNT_FULL);
    assign require  = !w_empty && (label_q[head_q] == '0);
    assign opOut    = w_empty ? 1'b0 : op_q[head_q];
    assign dataOut  = w_empty ? '0   : data_q[head_q];
    assign labelOut = w_empty ? '0   : label_q[head_q];

    // A full queue refuses the write even when the head leaves this cycle.
    assign w_push   = WEN && !isFull;
    assign w_pop    = requireAC && require;
    assign w_bc_hit = BCEN && (BClabel != '0);
    assign w_bypass = w_bc_hit && (labelIn == BClabel);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_push) tail_d = tail_q + PTR_ONE;
        if (w_pop)  head_d = head_q + PTR_ONE;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(i);

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    valid_q[i] <= 1'b0;
                    op_q[i]    <= 1'b0;
                    data_q[i]  <= '0;
                    label_q[i] <= '0;
                end else if (w_push && (tail_q == IDX)) begin
                    valid_q[i] <= 1'b1;
                    op_q[i]    <= opIn;
                    data_q[i]  <= w_bypass ? BCdata : dataIn;
                    label_q[i] <= w_bypass ? '0 : labelIn;
                end else if (w_pop && (head_q == IDX)) begin
                    valid_q[i] <= 1'b0;
                end else if (valid_q[i] && w_bc_hit && (label_q[i] == BClabel)) begin
                    data_q[i]  <= BCdata;
                    label_q[i] <= '0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue
//  Description : Directed self-checking bench for the issue queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        WEN = 1'b0;
    logic        opIn = 1'b0;
    logic [31:0] dataIn = '0;
    logic [4:0]  labelIn = '0;
    logic        isFull;
    logic        require;
    logic        requireAC = 1'b0;
    logic        opOut;
    logic [31:0] dataOut;
    logic [4:0]  labelOut;
    logic        BCEN = 1'b0;
    logic [4:0]  BClabel = '0;
    logic [31:0] BCdata = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    queue #(.DEPTH(8), .DATA_W(32), .LABEL_W(5)) dut (
        .clk(clk), .nRST(nRST), .WEN(WEN), .opIn(opIn), .dataIn(dataIn),
        .labelIn(labelIn), .isFull(isFull), .require(require),
        .requireAC(requireAC), .opOut(opOut), .dataOut(dataOut),
        .labelOut(labelOut), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [31:0] d, input logic [4:0] l);
        WEN = 1'b1; opIn = op; dataIn = d; labelIn = l;
        step();
        WEN = 1'b0; opIn = 1'b0; dataIn = '0; labelIn = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #2;
        n_vec++;
        if ({isFull, require, opOut, dataOut, labelOut} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got full=%b req=%b op=%b data=%0d label=%0d, want all 0",
                     isFull, require, opOut, dataOut, labelOut);
        end
        #10 nRST = 1'b1;
        step();
    endtask

    task automatic test_label_wait();
        push(1'b0, 32'd20, 5'd4);
        push(1'b0, 32'd30, 5'd5);
        n_vec++;
        if ({isFull, require, dataOut, labelOut} !== {1'b0, 1'b0, 32'd20, 5'd4}) begin
            n_err++;
            $display("FAIL label_wait: got full=%b req=%b data=%0d label=%0d, want 0 0 20 4",
                     isFull, require, dataOut, labelOut);
        end
    endtask

    task automatic test_broadcast();
        BCEN = 1'b1; BClabel = 5'd4; BCdata = 32'd25;
        step();
        BCEN = 1'b0; BClabel = '0; BCdata = '0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b1, 32'd25, 5'd0}) begin
            n_err++;
            $display("FAIL broadcast_head: got req=%b data=%0d label=%0d, want 1 25 0",
                     require, dataOut, labelOut);
        end
    endtask

    task automatic test_dequeue();
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b0, 32'd30, 5'd5}) begin
            n_err++;
            $display("FAIL dequeue_advance: got req=%b data=%0d label=%0d, want 0 30 5",
                     require, dataOut, labelOut);
        end
        // Accept while not ready must not pop.
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b0, 32'd30, 5'd5}) begin
            n_err++;
            $display("FAIL ack_not_ready: got req=%b data=%0d label=%0d, want 0 30 5",
                     require, dataOut, labelOut);
        end
        BCEN = 1'b1; BClabel = 5'd5; BCdata = 32'd99;
        step();
        BCEN = 1'b0; BClabel = '0; BCdata = '0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b1, 32'd99, 5'd0}) begin
            n_err++;
            $display("FAIL broadcast_second: got req=%b data=%0d label=%0d, want 1 99 0",
                     require, dataOut, labelOut);
        end
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
        n_vec++;
        if ({require, opOut, dataOut, labelOut} !== 39'd0) begin
            n_err++;
            $display("FAIL drain_empty: got req=%b op=%b data=%0d label=%0d, want 0 0 0 0",
                     require, opOut, dataOut, labelOut);
        end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 8; k++) begin
            push(k[0], 32'd100 + 32'(k), 5'd0);
            exp_q.push_back({k[0], 32'd100 + 32'(k)});
        end
        n_vec++;
        if ({isFull, require, opOut, dataOut} !== {1'b1, 1'b1, 1'b0, 32'd100}) begin
            n_err++;
            $display("FAIL fill_full: got full=%b req=%b op=%b data=%0d, want 1 1 0 100",
                     isFull, require, opOut, dataOut);
        end
        push(1'b1, 32'd999, 5'd0);
        n_vec++;
        if ({isFull, dataOut} !== {1'b1, 32'd100}) begin
            n_err++;
            $display("FAIL full_ignore: got full=%b data=%0d, want 1 100", isFull, dataOut);
        end
        // Write while full is dropped even though the head leaves this edge.
        WEN = 1'b1; dataIn = 32'd888; requireAC = 1'b1;
        step();
        WEN = 1'b0; dataIn = '0; requireAC = 1'b0;
        void'(exp_q.pop_front());
        n_vec++;
        if ({isFull, opOut, dataOut} !== {1'b0, exp_q[0]}) begin
            n_err++;
            $display("FAIL full_pop_push: got full=%b op=%b data=%0d, want 0 %b %0d",
                     isFull, opOut, dataOut, exp_q[0][32], exp_q[0][31:0]);
        end
        for (int j = 0; j < 20; j++) begin
            WEN = 1'b1; opIn = j[0]; dataIn = 32'd200 + 32'(j); requireAC = 1'b1;
            step();
            void'(exp_q.pop_front());
            exp_q.push_back({j[0], 32'd200 + 32'(j)});
            n_vec++;
            if ({isFull, require, opOut, dataOut} !== {1'b0, 1'b1, exp_q[0]}) begin
                n_err++;
                $display("FAIL pair_%0d: got full=%b req=%b op=%b data=%0d, want 0 1 %b %0d",
                         j, isFull, require, opOut, dataOut, exp_q[0][32], exp_q[0][31:0]);
            end
        end
        WEN = 1'b0; opIn = 1'b0; dataIn = '0; requireAC = 1'b0;
        push(1'b1, 32'd300, 5'd0);
        exp_q.push_back({1'b1, 32'd300});
        n_vec++;
        if (isFull !== 1'b1) begin
            n_err++;
            $display("FAIL count_kept: got full=%b, want 1", isFull);
        end
        for (int k = 0; k < 8; k++) begin
            requireAC = 1'b1;
            step();
            void'(exp_q.pop_front());
            n_vec++;
            if (exp_q.size() > 0) begin
                if ({require, opOut, dataOut} !== {1'b1, exp_q[0]}) begin
                    n_err++;
                    $display("FAIL drain_%0d: got req=%b op=%b data=%0d, want 1 %b %0d",
                             k, require, opOut, dataOut, exp_q[0][32], exp_q[0][31:0]);
                end
            end else if ({require, dataOut} !== 33'd0) begin
                n_err++;
                $display("FAIL drain_%0d: got req=%b data=%0d, want 0 0", k, require, dataOut);
            end
        end
        requireAC = 1'b0;
    endtask

    task automatic test_bypass();
        BCEN = 1'b1; BClabel = 5'd2; BCdata = 32'd7;
        push(1'b1, 32'd0, 5'd2);
        BCEN = 1'b0; BClabel = '0; BCdata = '0;
        n_vec++;
        if ({require, opOut, dataOut, labelOut} !== {1'b1, 1'b1, 32'd7, 5'd0}) begin
            n_err++;
            $display("FAIL bypass: got req=%b op=%b data=%0d label=%0d, want 1 1 7 0",
                     require, opOut, dataOut, labelOut);
        end
        push(1'b0, 32'd0, 5'd3);
        BCEN = 1'b1; BClabel = 5'd0; BCdata = 32'd55;
        step();
        BCEN = 1'b0; BCdata = '0;
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b0, 32'd0, 5'd3}) begin
            n_err++;
            $display("FAIL bc_label0: got req=%b data=%0d label=%0d, want 0 0 3",
                     require, dataOut, labelOut);
        end
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
        BCEN = 1'b1; BClabel = 5'd3; BCdata = 32'd33;
        step();
        BCEN = 1'b0; BClabel = '0; BCdata = '0;
        n_vec++;
        if ({require, dataOut, labelOut} !== {1'b1, 32'd33, 5'd0}) begin
            n_err++;
            $display("FAIL bc_after_block: got req=%b data=%0d label=%0d, want 1 33 0",
                     require, dataOut, labelOut);
        end
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
    endtask

    task automatic test_async_reset();
        push(1'b1, 32'd1, 5'd0);
        push(1'b0, 32'd2, 5'd0);
        push(1'b1, 32'd3, 5'd0);
        #2 nRST = 1'b0;
        #1;
        n_vec++;
        if ({isFull, require, opOut, dataOut, labelOut} !== 39'd0) begin
            n_err++;
            $display("FAIL async_reset: got full=%b req=%b op=%b data=%0d label=%0d, want all 0",
                     isFull, require, opOut, dataOut, labelOut);
        end
        #3 nRST = 1'b1;
        step();
        n_vec++;
        if ({require, dataOut} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_empty: got req=%b data=%0d, want 0 0", require, dataOut);
        end
        push(1'b1, 32'd77, 5'd0);
        n_vec++;
        if ({require, opOut, dataOut} !== {1'b1, 1'b1, 32'd77}) begin
            n_err++;
            $display("FAIL post_reset_push: got req=%b op=%b data=%0d, want 1 1 77",
                     require, opOut, dataOut);
        end
    endtask

    initial begin
        test_reset();
        test_label_wait();
        test_broadcast();
        test_dequeue();
        test_full_wrap();
        test_bypass();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
